// File: rtl/div_pkg.sv
// Shared types for the sequential divider: FSM state encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
`timescale 1ns/1ps
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration counter width: $clog2(width), never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of divisor from the shifted partial remainder.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   t       WIDTH+1-bit trial value {P[WIDTH-1:0], next dividend bit}
//   divisor WIDTH-bit unsigned divisor
//   diff    low WIDTH bits of t - divisor (only meaningful when ge=1)
//   ge      1 when t >= divisor
`timescale 1ns/1ps
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   t,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] diff,
   output logic             ge
);

   logic [WIDTH:0] sum;

   // Two's-complement subtract on the low WIDTH bits; carry out means no borrow.
   assign sum  = {1'b0, t[WIDTH-1:0]} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
   // A set top bit of t already exceeds any WIDTH-bit divisor.
   assign ge   = t[WIDTH] | sum[WIDTH];
   // When ge=1 the true difference is below the divisor, so WIDTH bits hold it.
   assign diff = sum[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock (start/done handshake).
// Latency: WIDTH cycles in RUN plus one DONE cycle; divide-by-zero goes straight to DONE.
// Backpressure: start is ignored while busy; results hold until the next operation's done.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request, accepted in IDLE or DONE
//   dividend, divisor   operands, captured on accepted start
//   busy                high while iterating
//   done                one-cycle pulse, results valid from this cycle
//   quotient, remainder results, held until the next done
//   div_by_zero         set with done when the divisor was zero
`timescale 1ns/1ps
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   // Partial remainder is always below the divisor between steps, so its
   // top bit is architecturally zero and only WIDTH bits are stored.
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvsr;

   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] diff;
   logic             ge;
   logic [WIDTH-1:0] p_nxt;
   logic [WIDTH-1:0] q_nxt;

   assign t     = {p, q[WIDTH-1]};
   assign p_nxt = ge ? diff : t[WIDTH-1:0];
   assign q_nxt = {q[WIDTH-2:0], ge};

   div_step #(.WIDTH(WIDTH)) u_step (
      .t       (t),
      .divisor (dvsr),
      .diff    (diff),
      .ge      (ge)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         p           <= '0;
         q           <= '0;
         dvsr        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            // DONE accepts a new start exactly like IDLE for back-to-back use.
            IDLE, DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (start) begin
                  q    <= dividend;
                  p    <= '0;
                  dvsr <= divisor;
                  cnt  <= '0;
                  if (divisor == '0) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               p   <= p_nxt;
               q   <= q_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= q_nxt;
                  remainder   <= p_nxt;
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner sequences, exhaustive and random sweeps.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_seq_divider;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int tests  = 0;
   int failed = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] dd;
      logic [W-1:0] dv;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer division; divide-by-zero yields all ones r dividend.
   task automatic ref_div(input int dd, input int dv, output int q, output int r, output int dz);
      if (dv == 0) begin
         q  = (1 << W) - 1;
         r  = dd;
         dz = 1;
      end else begin
         q  = dd / dv;
         r  = dd % dv;
         dz = 0;
      end
   endtask

   // Issue one operation, follow it to done, check results, latency, busy
   // duration, one-cycle done width and hold of results in the next cycle.
   task automatic run_op(input int dd, input int dv, input int eq, input int er, input int edz);
      int  lat;
      int  bcnt;
      bit  got;
      @(negedge clk);
      dividend = W'(dd);
      divisor  = W'(dv);
      start    = 1'b1;
      lat  = 0;
      bcnt = 0;
      got  = 1'b0;
      for (int i = 0; i < 4 * W && !got; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (i == 0) begin
            start    = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
         if (busy) bcnt++;
         if (done) got = 1'b1;
      end
      if (!got) begin
         check($sformatf("timeout %0d/%0d", dd, dv), 0, 1);
         return;
      end
      check($sformatf("quotient %0d/%0d", dd, dv), int'(quotient), eq);
      check($sformatf("remainder %0d/%0d", dd, dv), int'(remainder), er);
      check($sformatf("div_by_zero %0d/%0d", dd, dv), int'(div_by_zero), edz);
      check($sformatf("latency %0d/%0d", dd, dv), lat, (dv == 0) ? 1 : W + 1);
      check($sformatf("busy_cycles %0d/%0d", dd, dv), bcnt, (dv == 0) ? 0 : W);
      @(posedge clk);
      #1;
      check($sformatf("done_width %0d/%0d", dd, dv), int'(done), 0);
      check($sformatf("hold_quotient %0d/%0d", dd, dv), int'(quotient), eq);
      check($sformatf("hold_remainder %0d/%0d", dd, dv), int'(remainder), er);
   endtask

   // Wait for done, counting edges; start is dropped after each edge.
   task automatic wait_done(output int n, output bit got);
      n   = 0;
      got = 1'b0;
      while (!got && n < 4 * W) begin
         @(posedge clk);
         #1;
         n++;
         start = 1'b0;
         if (done) got = 1'b1;
      end
   endtask

   initial begin
      vec_t vecs[8];
      int   n;
      bit   got;
      int   eq, er, edz;
      int   a, b;

      vecs[0] = '{dd: 4'd13, dv: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0};
      vecs[1] = '{dd: 4'd15, dv: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
      vecs[2] = '{dd: 4'd7,  dv: 4'd9,  q: 4'd0,  r: 4'd7, dz: 1'b0};
      vecs[3] = '{dd: 4'd9,  dv: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1};
      vecs[4] = '{dd: 4'd10, dv: 4'd4,  q: 4'd2,  r: 4'd2, dz: 1'b0};
      vecs[5] = '{dd: 4'd0,  dv: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
      vecs[6] = '{dd: 4'd15, dv: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
      vecs[7] = '{dd: 4'd0,  dv: 4'd0,  q: 4'd15, r: 4'd0, dz: 1'b1};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset quotient", int'(quotient), 0);
      check("reset remainder", int'(remainder), 0);
      check("reset div_by_zero", int'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_op(int'(vecs[i].dd), int'(vecs[i].dv), int'(vecs[i].q), int'(vecs[i].r), int'(vecs[i].dz));

      // start pulsed during RUN must be ignored
      @(negedge clk);
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      dividend = 4'd6;
      divisor  = 4'd2;
      start    = 1'b1;
      wait_done(n, got);
      check("ignored_start found_done", int'(got), 1);
      check("ignored_start latency", n + 2, W + 1);
      check("ignored_start quotient", int'(quotient), 4);
      check("ignored_start remainder", int'(remainder), 1);

      // start in the DONE cycle is accepted back-to-back
      dividend = 4'd6;
      divisor  = 4'd2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b done_dropped", int'(done), 0);
      @(posedge clk);
      #1;
      check("b2b busy", int'(busy), 1);
      check("b2b hold_quotient", int'(quotient), 4);
      check("b2b hold_remainder", int'(remainder), 1);
      wait_done(n, got);
      check("b2b found_done", int'(got), 1);
      check("b2b latency", n + 2, W + 1);
      check("b2b quotient", int'(quotient), 3);
      check("b2b remainder", int'(remainder), 0);

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #3;
      check("pre_reset busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("async_reset busy", int'(busy), 0);
      check("async_reset done", int'(done), 0);
      check("async_reset quotient", int'(quotient), 0);
      check("async_reset remainder", int'(remainder), 0);
      check("async_reset div_by_zero", int'(div_by_zero), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(10, 4, 2, 2, 0);

      // exhaustive sweep against the reference
      for (int x = 0; x < (1 << W); x++) begin
         for (int y = 0; y < (1 << W); y++) begin
            ref_div(x, y, eq, er, edz);
            run_op(x, y, eq, er, edz);
         end
      end

      // random order operations
      for (int k = 0; k < 64; k++) begin
         a = int'($urandom_range((1 << W) - 1, 0));
         b = int'($urandom_range((1 << W) - 1, 0));
         ref_div(a, b, eq, er, edz);
         run_op(a, b, eq, er, edz);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
